// File: rtl/prog_loader.sv
// prog_loader: receives a 16-byte program image over an 8N1 UART line and
// replays it to the program RAM's programming port as one uninterrupted burst.
// byte_valid is a single-cycle strobe, and rx_shift holds the received byte
// during that cycle. There is no ready: the consumer takes the byte or it is lost.
module prog_loader #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DEPTH        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rx,
    input  logic       load_en,
    output logic       prog_mode,
    output logic [7:0] w_data,
    output logic       busy,
    output logic       done,
    output logic       frame_err,
    output logic [1:0] dbg_state,
    output logic [3:0] dbg_cnt
);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {ST_IDLE, ST_RECV, ST_STREAM, ST_DONE} state_t;

    localparam logic [7:0] HALF_M1 = 8'(CLKS_PER_BIT / 2 - 1);
    localparam logic [7:0] FULL_M1 = 8'(CLKS_PER_BIT - 1);

    logic       rx_meta, rx_sync;
    rx_state_t  rx_state, rx_state_n;
    logic [7:0] rx_cnt, rx_cnt_n;
    logic [2:0] rx_bit, rx_bit_n;
    logic [7:0] rx_shift, rx_shift_n;
    logic       byte_valid, stop_err;

    state_t     state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [4:0] idx, idx_n;
    logic       armed;
    logic       prog_mode_n, done_n, ferr_clr, buf_we;
    logic [7:0] w_data_n;
    logic [7:0] buf_mem [DEPTH];

    // Two-flop synchronizer; resets to the idle (high) line level.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= uart_rx;
            rx_sync <= rx_meta;
        end
    end

    // Receiver state and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_state <= RX_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
            rx_shift <= '0;
        end else begin
            rx_state <= rx_state_n;
            rx_cnt   <= rx_cnt_n;
            rx_bit   <= rx_bit_n;
            rx_shift <= rx_shift_n;
        end
    end

    // Receiver next state: half-bit start check, then samples at bit centres.
    always_comb begin
        rx_state_n = rx_state;
        rx_cnt_n   = rx_cnt + 8'd1;
        rx_bit_n   = rx_bit;
        rx_shift_n = rx_shift;
        byte_valid = 1'b0;
        stop_err   = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                rx_cnt_n = '0;
                if (!rx_sync) rx_state_n = RX_START;
            end
            RX_START: begin
                if (rx_cnt == HALF_M1) begin
                    rx_cnt_n   = '0;
                    rx_bit_n   = '0;
                    // A line that is high again at mid start bit is only a glitch.
                    rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt == FULL_M1) begin
                    rx_cnt_n   = '0;
                    rx_shift_n = {rx_sync, rx_shift[7:1]};
                    if (rx_bit == 3'd7) rx_state_n = RX_STOP;
                    else                rx_bit_n   = rx_bit + 3'd1;
                end
            end
            RX_STOP: begin
                if (rx_cnt == FULL_M1) begin
                    rx_cnt_n   = '0;
                    rx_state_n = RX_IDLE;
                    if (rx_sync) byte_valid = 1'b1;
                    else         stop_err   = 1'b1;
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    // Load FSM state, counters and registered RAM-port outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            idx       <= '0;
            prog_mode <= 1'b0;
            w_data    <= '0;
            done      <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            idx       <= idx_n;
            prog_mode <= prog_mode_n;
            w_data    <= w_data_n;
            done      <= done_n;
        end
    end

    // Armed latch needs load_en low before each load; sticky framing flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            armed     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (state == ST_DONE) armed <= 1'b0;
            else if (!load_en)    armed <= 1'b1;
            if (stop_err)      frame_err <= 1'b1;
            else if (ferr_clr) frame_err <= 1'b0;
        end
    end

    // Image buffer; contents are don't-care until a full image is received.
    always_ff @(posedge clk) begin
        if (buf_we) buf_mem[cnt] <= rx_shift;
    end

    // Load FSM next state. Outputs are computed one cycle ahead and registered,
    // so idx names the burst slot currently on w_data.
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        idx_n       = idx;
        prog_mode_n = 1'b0;
        w_data_n    = '0;
        done_n      = 1'b0;
        ferr_clr    = 1'b0;
        buf_we      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (load_en && armed) begin
                    state_n  = ST_RECV;
                    cnt_n    = '0;
                    ferr_clr = 1'b1;
                end
            end
            ST_RECV: begin
                // Abort takes priority over a byte arriving in the same cycle.
                if (!load_en) begin
                    state_n = ST_IDLE;
                end else if (byte_valid) begin
                    buf_we = 1'b1;
                    cnt_n  = cnt + 4'd1;
                    if (cnt == 4'(DEPTH - 1)) begin
                        state_n     = ST_STREAM;
                        idx_n       = '0;
                        prog_mode_n = 1'b1;
                    end
                end
            end
            ST_STREAM: begin
                // Slot 0 carries 0x00 while the RAM clears its write pointer.
                if (idx == 5'(DEPTH)) begin
                    state_n = ST_DONE;
                    done_n  = 1'b1;
                end else begin
                    idx_n       = idx + 5'd1;
                    prog_mode_n = 1'b1;
                    w_data_n    = buf_mem[idx[3:0]];
                end
            end
            ST_DONE: state_n = ST_IDLE;
            default: state_n = ST_IDLE;
        endcase
    end

    assign busy      = (state == ST_RECV) || (state == ST_STREAM);
    assign dbg_state = state;
    assign dbg_cnt   = cnt;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: table of full-image loads plus directed sequences
// for abort, glitch, retrigger and reset during a burst.
module tb_prog_loader;

  localparam int CPB = 8;
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RECV = 2'd1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       uart_rx = 1'b1;
  logic       load_en = 1'b0;
  logic       prog_mode, busy, done, frame_err;
  logic [7:0] w_data;
  logic [1:0] dbg_state;
  logic [3:0] dbg_cnt;

  prog_loader #(.CLKS_PER_BIT(CPB), .DEPTH(16)) dut (
    .clk(clk), .rst(rst), .uart_rx(uart_rx), .load_en(load_en),
    .prog_mode(prog_mode), .w_data(w_data), .busy(busy), .done(done),
    .frame_err(frame_err), .dbg_state(dbg_state), .dbg_cnt(dbg_cnt)
  );

  // clock
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // scoreboard: expected burst and what the RAM port actually saw
  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];
  logic [7:0] ram [16];
  logic [3:0] ram_ptr = 4'd0;
  int         rise_cnt = 0, done_cnt = 0, done_bad = 0, pm_cnt = 0;
  logic       pm_prev = 1'b0;

  typedef struct {
    logic [7:0] base;
    logic [7:0] step;
    logic       bad_first;
    logic       exp_ferr;
  } vec_t;
  vec_t vecs [4];

  // RAM-side monitor, sampled on the falling edge
  always @(negedge clk) begin
    if (prog_mode) begin
      got_q.push_back(w_data);
      pm_cnt++;
      if (!pm_prev) ram_ptr = 4'd0;
      else begin
        ram[ram_ptr] = w_data;
        ram_ptr = ram_ptr + 4'd1;
      end
    end
    if (prog_mode && !pm_prev) rise_cnt++;
    if (done) begin
      done_cnt++;
      if (!pm_prev || prog_mode || busy) done_bad++;
    end
    pm_prev = prog_mode;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    got_q.delete();
    rise_cnt = 0;
    done_cnt = 0;
    done_bad = 0;
    pm_cnt   = 0;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic stop_bit);
    uart_rx = 1'b0;
    tick(CPB);
    for (int b = 0; b < 8; b++) begin
      uart_rx = d[b];
      tick(CPB);
    end
    uart_rx = stop_bit;
    tick(CPB);
    uart_rx = 1'b1;
  endtask

  task automatic wait_done(input int bound);
    int k = 0;
    while (done_cnt == 0 && k < bound) begin
      tick(1);
      k++;
    end
    if (done_cnt == 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  // full image load with an optional bad frame first and a noise byte
  // started while the burst is streaming
  task automatic run_load(input string tag, input logic [7:0] base, input logic [7:0] step,
                          input logic bad_first, input logic exp_ferr);
    logic [7:0] b;
    int bad;
    load_en = 1'b0;
    tick(3);
    clear_mon();
    load_en = 1'b1;
    tick(3);
    check({tag, "_ferr_cleared"}, frame_err, 1'b0);
    check({tag, "_busy_recv"}, busy, 1'b1);
    if (bad_first) begin
      send_byte(8'hA5, 1'b0);
      tick(2 * CPB);
    end
    exp_q.delete();
    exp_q.push_back(8'h00);
    b = base;
    for (int k = 0; k < 16; k++) begin
      exp_q.push_back(b);
      send_byte(b, 1'b1);
      b = b + step;
    end
    send_byte(8'hEE, 1'b1);
    wait_done(200);
    tick(5);
    check({tag, "_burst_len"}, got_q.size(), 32'd17);
    for (int k = 0; k < 17; k++) begin
      if (k < got_q.size())
        check($sformatf("%s_w_data_%0d", tag, k), got_q[k], exp_q[k]);
    end
    check({tag, "_pm_rises"}, rise_cnt, 32'd1);
    check({tag, "_pm_cycles"}, pm_cnt, 32'd17);
    check({tag, "_done_pulses"}, done_cnt, 32'd1);
    check({tag, "_done_timing"}, done_bad, 32'd0);
    check({tag, "_frame_err"}, frame_err, exp_ferr);
    bad = 0;
    for (int a = 0; a < 16; a++) if (ram[a] !== exp_q[a + 1]) bad++;
    check({tag, "_ram_image"}, bad, 32'd0);
    check({tag, "_state_idle"}, dbg_state, S_IDLE);
    check({tag, "_cnt_zero"}, dbg_cnt, 4'd0);
  endtask

  initial begin
    int k;
    vecs[0] = '{8'h10, 8'h01, 1'b0, 1'b0};
    vecs[1] = '{8'hA0, 8'h0B, 1'b1, 1'b1};
    vecs[2] = '{8'hFF, 8'hFF, 1'b0, 1'b0};
    vecs[3] = '{8'h5A, 8'h00, 1'b1, 1'b1};

    // reset: asynchronous, checked before any clock edge
    load_en = 1'b1;
    #2 rst = 1'b0;
    #1;
    check("rst_prog_mode", prog_mode, 1'b0);
    check("rst_w_data", w_data, 8'h00);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_frame_err", frame_err, 1'b0);
    check("rst_state", dbg_state, S_IDLE);
    tick(2);
    rst = 1'b1;
    tick(4);
    check("rst_unarmed", dbg_state, S_IDLE);

    // table-driven loads
    for (int v = 0; v < 4; v++)
      run_load($sformatf("vec%0d", v), vecs[v].base, vecs[v].step, vecs[v].bad_first, vecs[v].exp_ferr);

    // retrigger: load_en still high after DONE, a new image must be ignored
    clear_mon();
    for (int j = 0; j < 16; j++) send_byte(8'h77, 1'b1);
    tick(20);
    check("retrig_no_burst", rise_cnt, 32'd0);
    check("retrig_state", dbg_state, S_IDLE);
    check("retrig_cnt", dbg_cnt, 4'd0);

    // abort with a glitch in the middle
    load_en = 1'b0;
    tick(3);
    clear_mon();
    load_en = 1'b1;
    tick(3);
    send_byte(8'hC0, 1'b1);
    send_byte(8'hC1, 1'b1);
    tick(4);
    uart_rx = 1'b0;
    tick(2);
    uart_rx = 1'b1;
    tick(40);
    check("glitch_cnt", dbg_cnt, 4'd2);
    check("glitch_ferr", frame_err, 1'b0);
    check("glitch_state", dbg_state, S_RECV);
    send_byte(8'hC2, 1'b1);
    send_byte(8'hC3, 1'b1);
    send_byte(8'hC4, 1'b1);
    check("abort_cnt5", dbg_cnt, 4'd5);
    load_en = 1'b0;
    tick(3);
    check("abort_state", dbg_state, S_IDLE);
    check("abort_busy", busy, 1'b0);
    check("abort_no_burst", rise_cnt, 32'd0);
    run_load("fresh", 8'h30, 8'h01, 1'b0, 1'b0);

    // reset in the middle of a burst
    load_en = 1'b0;
    tick(3);
    clear_mon();
    load_en = 1'b1;
    tick(3);
    for (int j = 0; j < 16; j++) send_byte(8'(8'h40 + j), 1'b1);
    k = 0;
    while (pm_cnt < 9 && k < 100) begin
      @(negedge clk);
      #1;
      k++;
    end
    check("mid_reached_i8", (pm_cnt >= 9), 1'b1);
    check("mid_w_data_i8", w_data, 8'h47);
    rst = 1'b0;
    #1;
    check("mid_rst_prog_mode", prog_mode, 1'b0);
    check("mid_rst_w_data", w_data, 8'h00);
    check("mid_rst_busy", busy, 1'b0);
    check("mid_rst_done", done, 1'b0);
    check("mid_rst_ferr", frame_err, 1'b0);
    check("mid_rst_state", dbg_state, S_IDLE);
    check("mid_rst_cnt", dbg_cnt, 4'd0);
    tick(2);
    rst = 1'b1;
    tick(4);
    check("mid_rst_unarmed", dbg_state, S_IDLE);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
# prog_loader

Serial program loader that sits directly upstream of the program RAM. It receives 16 bytes over an 8N1 UART line into a local buffer. Once the buffer is full, it drives the RAM's programming port (`prog_mode`, `w_data`) with one uninterrupted burst, so the RAM image is never partially overwritten. This lets the 8-bit CPU be reprogrammed through a single input pin.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 16: clocks per UART bit. Legal values are 4 to 255; the value must be even.
- `DEPTH`, default 16: bytes per program image. It is fixed to match the 4-bit RAM address.

Ports:
- `clk` in 1: the single clock. All logic is on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `uart_rx` in 1: serial data. Idle level is high; asynchronous to `clk`.
- `load_en` in 1: level that arms a load.
- `prog_mode` out 1: registered. Drives the program RAM's `prog_mode`.
- `w_data` out 8: registered. Drives the program RAM's `w_data`.
- `busy` out 1: high in RECV and STREAM.
- `done` out 1: one-cycle pulse when a burst completes.
- `frame_err` out 1: sticky flag; set when a stop bit is sampled low.

## Operation

- **Input sync:** `uart_rx` passes through a 2-flop synchronizer before any use.
- **UART receiver:** runs in every state.
  - A low level on the synced line while the receiver is idle starts a frame.
  - At `CLKS_PER_BIT/2` the line is re-checked. If it is high, the event is a glitch and the receiver returns to idle.
  - Eight data bits are sampled, LSB first, every `CLKS_PER_BIT` after the start-bit midpoint.
  - The stop bit is sampled one `CLKS_PER_BIT` later.
  - Stop bit high: `byte_valid` pulses for 1 cycle.
  - Stop bit low: no `byte_valid`, `frame_err` is set, and the byte is discarded.
- **FSM states:** IDLE, RECV, STREAM, DONE.
  - IDLE: enter RECV when `load_en`=1 and the armed latch is set. Clear `cnt` and `frame_err`. Bytes that arrive in IDLE are ignored.
  - RECV: each `byte_valid` writes `buf[cnt]` and increments `cnt` (4-bit). The byte that makes `cnt` wrap from 15 to 0 moves the FSM to STREAM. If `load_en`=0, the FSM aborts to IDLE, the buffer contents become don't-care, and `prog_mode` is never raised.
  - STREAM: `prog_mode`=1 for exactly `DEPTH`+1 = 17 consecutive cycles, counted by a 5-bit index `i` from 0 to 16.
    - i=0: `w_data`=0x00. This is the cycle the RAM spends clearing its write pointer.
    - i=1..16: `w_data`=`buf[i-1]`.
    - `load_en` and `byte_valid` are ignored throughout. The burst is never truncated.
  - DONE: `prog_mode`=0 and `done`=1 for one cycle, then IDLE. The armed latch is cleared.
- **Armed latch:** set whenever `load_en`=0 and cleared in DONE. A new load therefore requires `load_en` to go low and then high again. Holding `load_en` high does not retrigger.
- **`busy`:** 1 in RECV and STREAM, 0 otherwise.

## Timing

- Reset (async, `rst`=0):
  - `prog_mode`=0, `w_data`=0x00, `busy`=0, `done`=0, `frame_err`=0.
  - FSM in IDLE, `cnt`=0.
  - Armed latch clear; it sets on the first cycle after reset with `load_en`=0.
  - Receiver idle; synchronizer flops reset to 1.
  - `prog_mode` drops in the same instant, with no clock needed.
- Reset mid-STREAM: the burst is abandoned. The RAM contents are then undefined and the user must reload.
- Receiver latency: `byte_valid` occurs about 9.5 × `CLKS_PER_BIT` + 2 (sync) cycles after the start-bit falling edge.
- Burst start: `prog_mode` rises on the cycle after the 16th `byte_valid`.
- Burst length: `prog_mode` is high for exactly 17 cycles. `w_data` changes on the same edge as `i` advances.
- Completion: `done` is high on the first cycle with `prog_mode`=0 after the burst. `busy` falls on that same edge.
- Back-to-back frames: a frame may start the cycle after the previous stop-bit sample. No bytes are lost at CLKS_PER_BIT ≥ 4.
- `load_en` deassert in the same cycle as the 16th `byte_valid`: the abort wins and there is no burst.

## Test plan

(Bench uses `CLKS_PER_BIT`=8.)
- **Normal load:** after reset, `load_en`=1; send bytes 0x10..0x1F → `prog_mode` high for exactly 17 cycles; `w_data` sequence is 0x00, 0x10, 0x11 … 0x1F; `done` pulses once; a RAM model reads back 0x10..0x1F at addresses 0..15.
- **Abort:** send 5 bytes, drop `load_en` → FSM returns to IDLE, `prog_mode` never rises. Re-assert `load_en` and send 16 fresh bytes → the burst contains only the fresh bytes.
- **Framing error:** send 0xA5 with stop bit low, then 16 good bytes → `frame_err`=1 and the bad byte is absent from the burst. The next `load_en` rising edge clears `frame_err`.
- **Glitch rejection:** a 2-cycle low pulse on `uart_rx` → no `byte_valid`, `cnt` unchanged.
- **Retrigger and noise:** hold `load_en` high through DONE → no second load. Send bytes during STREAM → burst unchanged, `cnt`=0 afterwards.
- **Reset mid-STREAM:** assert `rst` at i=8 → `prog_mode`=0 immediately and all outputs are at their reset values.
